// File: rtl/read_sense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : read_sense_ctrl
//  Description: Sequences one SRAM read (precharge, wordline/develop, sense)
//               and resolves each column's differential bitline pair into a
//               latched data word, an error flag and a one-cycle valid pulse.
//  Revision   : 1.0 - initial release
// ============================================================================
module read_sense_ctrl #(
    parameter int COLS       = 8,
    parameter int PRE_CYCLES = 2,
    parameter int DEV_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_req,
    input  logic            rd_abort,
    output logic            rd_ready,
    input  logic [COLS-1:0] bl_rd,
    input  logic [COLS-1:0] blb_rd,
    output logic            precharge_en,
    output logic            wl_en,
    output logic            sae,
    output logic [COLS-1:0] data_out,
    output logic            data_valid,
    output logic            rd_err
);

    // One shared phase counter, sized for the longer of the two timed phases.
    localparam int CNT_MAX = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_pre_last = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dev_last = CNT_W'(DEV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_DEV   = 3'd2,
        S_SENSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    // Column resolution: a proper differential gives bl; a collapsed pair reads 0 and flags an error.
    logic [COLS-1:0]  w_data;
    logic             w_err;

    assign w_data = bl_rd & ~blb_rd;
    assign w_err  = |(~(bl_rd ^ blb_rd));

    // State and phase counter register; reset drops all control outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic; abort wins over everything except the DONE pulse.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (rd_req && !rd_abort) begin
                    w_next_state = S_PRE;
                    w_next_cnt   = '0;
                end
            end
            S_PRE: begin
                if (rd_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == c_pre_last) begin
                    w_next_state = S_DEV;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            S_DEV: begin
                if (rd_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == c_dev_last) begin
                    w_next_state = S_SENSE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            S_SENSE: begin
                w_next_state = rd_abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state only.
    assign rd_ready     = (r_state == S_IDLE);
    assign precharge_en = (r_state == S_PRE);
    assign wl_en        = (r_state == S_DEV) || (r_state == S_SENSE);
    assign sae          = (r_state == S_SENSE);
    assign data_valid   = (r_state == S_DONE);

    // Capture the resolved word on the closing edge of SENSE unless the read is aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_err   <= 1'b0;
        end else if ((r_state == S_SENSE) && !rd_abort) begin
            data_out <= w_data;
            rd_err   <= w_err;
        end
    end

endmodule
`default_nettype wire
